// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM between NUM_REQ sprite mappers on the
//   VGA pixel clock. Each edge one requester is granted (round-robin, with
//   optional burst lock), its address is registered onto rom_address, and
//   the grant is delayed by ROM_LATENCY registers to tag the returned data.
//
// Ports
//   vga_clk          pixel clock, all logic on posedge
//   reset            synchronous active-high reset
//   req              per-requester level request, held until granted
//   lock             per-requester burst lock (only effective while granted)
//   req_addr         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt              registered one-hot grant, zero when idle
//   rom_address      registered ROM address
//   rom_q            ROM read data
//   rsp_valid        one-hot owner of rsp_data
//   rsp_data         rom_q passed through
//   contention_count (SPRITE_ARB_STATS_EN only) saturating count of edges
//                    with more than one request pending
//
// Optional feature macro: SPRITE_ARB_STATS_EN
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 5,
    parameter int ROM_LATENCY = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rsp_valid,
`ifdef SPRITE_ARB_STATS_EN
    output logic [15:0]               contention_count,
`endif
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int LAST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [LAST_W-1:0]  last;
    logic [LAST_W-1:0]  win;
    logic [LAST_W-1:0]  cand;
    logic               found;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ADDR_W-1:0]  win_addr;
    logic [NUM_REQ-1:0] rsp_pipe [ROM_LATENCY];

    // Winner selection: a granted, still-requesting, locked owner keeps the
    // bus; otherwise scan upward from the requester after the last winner.
    always_comb begin
        found = 1'b0;
        win   = last;
        cand  = last;
        if (lock[last] && req[last] && gnt[last]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = LAST_W'((int'(last) + k) % NUM_REQ);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == LAST_W'(i)) begin
                win_onehot[i] = found;
                win_addr      = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            gnt         <= '0;
            rom_address <= '0;
            last        <= LAST_W'(NUM_REQ - 1);
        end else if (found) begin
            gnt         <= win_onehot;
            rom_address <= win_addr;
            last        <= win;
        end else begin
            gnt <= '0;
        end
    end

    // Grant tag travels alongside the ROM read so the data returns to its owner.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int s = 0; s < ROM_LATENCY; s++) rsp_pipe[s] <= '0;
        end else begin
            rsp_pipe[0] <= gnt;
            for (int s = 1; s < ROM_LATENCY; s++) rsp_pipe[s] <= rsp_pipe[s-1];
        end
    end

    assign rsp_valid = rsp_pipe[ROM_LATENCY-1];
    assign rsp_data  = rom_q;

`ifdef SPRITE_ARB_STATS_EN
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            contention_count <= '0;
        end else if (($countones(req) > 1) && (contention_count != 16'hFFFF)) begin
            contention_count <= contention_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Directed bench for sprite_rom_arbiter. Two instances share stimulus:
//   dut1 with ROM_LATENCY=1 and dut2 with ROM_LATENCY=2, each with its own
//   behavioural ROM. Optional stats checks compile with SPRITE_ARB_STATS_EN.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 5;

    logic                      vga_clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;

    logic [NUM_REQ-1:0] gnt1, gnt2, rsp_valid1, rsp_valid2;
    logic [ADDR_W-1:0]  rom_address1, rom_address2;
    logic [DATA_W-1:0]  rom_q1, rom_q2, rom_q2a, rsp_data1, rsp_data2;
`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] contention_count1, contention_count2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a * 11'd7 + 11'd3;
        return t[DATA_W-1:0];
    endfunction

    // Behavioural ROMs: registered read of depth 1 and 2.
    always @(posedge vga_clk) begin
        rom_q1  <= rom_f(rom_address1);
        rom_q2a <= rom_f(rom_address2);
        rom_q2  <= rom_q2a;
    end

    sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(1)) dut1 (
        .vga_clk(vga_clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
        .gnt(gnt1), .rom_address(rom_address1), .rom_q(rom_q1), .rsp_valid(rsp_valid1),
`ifdef SPRITE_ARB_STATS_EN
        .contention_count(contention_count1),
`endif
        .rsp_data(rsp_data1)
    );

    sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LATENCY(2)) dut2 (
        .vga_clk(vga_clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
        .gnt(gnt2), .rom_address(rom_address2), .rom_q(rom_q2), .rsp_valid(rsp_valid2),
`ifdef SPRITE_ARB_STATS_EN
        .contention_count(contention_count2),
`endif
        .rsp_data(rsp_data2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [ADDR_W-1:0] addrs [4];

    initial begin
        reset    = 1'b1;
        req      = '0;
        lock     = '0;
        req_addr = '0;

        // Reset state
        do_reset();
        check_val("rst_gnt", 32'(gnt1), 32'h0);
        check_val("rst_addr", 32'(rom_address1), 32'h0);
        check_val("rst_rsp", 32'(rsp_valid1), 32'h0);
        check_val("rst_rsp2", 32'(rsp_valid2), 32'h0);

        // Single request, uncontended
        req = 4'b0001;
        set_addr(0, 11'd100);
        tick();
        check_val("single_gnt", 32'(gnt1), 32'h1);
        check_val("single_addr", 32'(rom_address1), 32'd100);
        check_val("single_rsp_early", 32'(rsp_valid1), 32'h0);
        req = 4'b0000;
        tick();
        check_val("single_rsp", 32'(rsp_valid1), 32'h1);
        check_val("single_data", 32'(rsp_data1), 32'(rom_f(11'd100)));
        check_val("single_gnt_idle", 32'(gnt1), 32'h0);
        tick();
        check_val("single_rsp_off", 32'(rsp_valid1), 32'h0);

        // All four requesting from the first cycle after reset
        do_reset();
        addrs[0] = 11'd10; addrs[1] = 11'd20; addrs[2] = 11'd30; addrs[3] = 11'd40;
        for (int i = 0; i < 4; i++) set_addr(i, addrs[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("rr_gnt%0d", k), 32'(gnt1), 32'(4'b0001 << (k % 4)));
            check_val($sformatf("rr_addr%0d", k), 32'(rom_address1), 32'(addrs[k % 4]));
            if (k > 0) begin
                check_val($sformatf("rr_rsp%0d", k), 32'(rsp_valid1), 32'(4'b0001 << ((k - 1) % 4)));
                check_val($sformatf("rr_data%0d", k), 32'(rsp_data1), 32'(rom_f(addrs[(k - 1) % 4])));
            end
        end
        req = 4'b0000;
        tick();
        check_val("rr_idle_gnt", 32'(gnt1), 32'h0);

        // Burst lock on requester 1 against requester 2 (last winner was 0)
        req  = 4'b0110;
        lock = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("lock_gnt%0d", k), 32'(gnt1), 32'h2);
        end
        lock = 4'b0000;
        tick();
        check_val("unlock_gnt_a", 32'(gnt1), 32'h4);
        tick();
        check_val("unlock_gnt_b", 32'(gnt1), 32'h2);
        req = 4'b0000;
        tick();

        // Lock held by a requester that does not own the grant is ignored
        do_reset();
        req  = 4'b0011;
        lock = 4'b0010;
        tick();
        check_val("lock_nogrant_a", 32'(gnt1), 32'h1);
        lock = 4'b0000;
        tick();
        check_val("lock_nogrant_b", 32'(gnt1), 32'h2);

        // Reset one cycle after a grant to requester 3 drops the read
        do_reset();
        req = 4'b1000;
        set_addr(3, 11'd77);
        tick();
        check_val("rst3_gnt_pre", 32'(gnt1), 32'h8);
        check_val("rst3_addr_pre", 32'(rom_address1), 32'd77);
        reset = 1'b1;
        tick();
        check_val("rst3_gnt", 32'(gnt1), 32'h0);
        check_val("rst3_addr", 32'(rom_address1), 32'h0);
        check_val("rst3_rsp", 32'(rsp_valid1), 32'h0);
        check_val("rst3_rsp2", 32'(rsp_valid2), 32'h0);
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        check_val("rst3_drop1", 32'(rsp_valid1), 32'h0);
        check_val("rst3_drop2", 32'(rsp_valid2), 32'h0);
        req = 4'b1001;
        tick();
        check_val("rst3_first", 32'(gnt1), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        tick();

        // ROM_LATENCY = 2 response timing on requester 2
        do_reset();
        req = 4'b0100;
        set_addr(2, 11'd55);
        tick();
        check_val("lat2_gnt", 32'(gnt2), 32'h4);
        check_val("lat2_addr", 32'(rom_address2), 32'd55);
        req = 4'b0000;
        tick();
        check_val("lat2_rsp_t1", 32'(rsp_valid2), 32'h0);
        check_val("lat1_rsp_t1", 32'(rsp_valid1), 32'h4);
        tick();
        check_val("lat2_rsp_t2", 32'(rsp_valid2), 32'h4);
        check_val("lat2_data", 32'(rsp_data2), 32'(rom_f(11'd55)));
        tick();
        check_val("lat2_rsp_t3", 32'(rsp_valid2), 32'h0);

`ifdef SPRITE_ARB_STATS_EN
        do_reset();
        check_val("stats_rst", 32'(contention_count1), 32'h0);
        req = 4'b0011;
        for (int k = 0; k < 3; k++) tick();
        req = 4'b0001;
        for (int k = 0; k < 2; k++) tick();
        check_val("stats_count3", 32'(contention_count1), 32'd3);
        req = 4'b1111;
        for (int k = 0; k < 65540; k++) tick();
        check_val("stats_sat", 32'(contention_count1), 32'hFFFF);
        req = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (registered read, address-in to q-out latency ROM_LATENCY) between up to NUM_REQ sprite mappers, e.g. guard, player and projectile.
- Per cycle: round-robin grant of one requester, registered drive of the ROM address, and routing of the returned palette index back with a one-hot valid.
- Sits between the per-sprite mappers and the single shared ROM instance, on the VGA pixel clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 11, ROM address width.
- DATA_W, 5, ROM data (palette index) width.
- ROM_LATENCY, 1, clocks from rom_address registered to rom_q valid (1 or 2).

Ports:
- vga_clk  input  1  pixel clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester read request, level, held until granted.
- lock  input  NUM_REQ  per-requester burst lock; meaningful only while that requester is granted.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  output  NUM_REQ  registered one-hot grant (all-zero when idle).
- rom_address  output  ADDR_W  registered address to the ROM.
- rom_q  input  DATA_W  ROM read data.
- rsp_valid  output  NUM_REQ  one-hot; rsp_data belongs to the set bit.
- rsp_data  output  DATA_W  equals rom_q (combinational pass-through).

Behaviour:
- Reset (synchronous; overrides everything, including mid-burst or with reads in flight):
  - gnt = 0, rom_address = 0, rsp_valid = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins the first contention.
  - Latency pipeline cleared; in-flight reads are dropped and never produce rsp_valid.
- Arbitration (each posedge, not in reset):
  - If lock[last] & req[last] & gnt[last]: regrant last (burst continues, no rotation).
  - Else: grant the first i with req[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - Any grant updates last to the winner. No req: gnt <= 0, last unchanged, rom_address holds its value.
- Address: on the edge that sets gnt[i], rom_address <= req_addr[i] (value sampled at that edge).
- Requester handshake:
  - Sampling gnt[i]=1 in cycle t means the address it presented in cycle t-1 was consumed.
  - It may present a new address, or drop req, in cycle t.
  - A request is never lost: req held high is eventually granted, within NUM_REQ-1 grants to others when no lock is held.
- Response:
  - rsp_valid is gnt delayed by ROM_LATENCY registers, so rsp_valid[i] is high exactly ROM_LATENCY cycles after gnt[i].
  - rsp_data = rom_q.
  - Back-to-back grants give back-to-back responses, one per cycle, in grant order.
- Throughput: one read per cycle total; a single requester holding req continuously is granted every cycle.
- Lock:
  - A locked requester keeps the grant every cycle while req stays high.
  - Dropping req or lock releases arbitration at the next edge.
  - lock without a current grant has no effect.
- Simultaneous req rise from all requesters after reset: grant order 0,1,2,3,0,...
- Latency from req assertion (no contention) to rsp_valid: 1 + ROM_LATENCY cycles.

Optional Feature:
- Macro: SPRITE_ARB_STATS_EN.
- Defined:
  - Extra output contention_count, 16 bits, registered.
  - Increments on every edge where more than one req bit is high; saturates at 16'hFFFF.
  - Cleared to 0 by reset.
- Undefined: port and counter absent; arbitration behaviour identical.

Test Plan:
- Reset then single req[0]=1, req_addr[0]=11'd100, ROM_LATENCY=1 -> gnt=4'b0001 one cycle later with rom_address=100. The next cycle rsp_valid=4'b0001 and rsp_data=ROM[100].
- All four req held from the first cycle after reset, each with a distinct address -> gnt sequence 0001,0010,0100,1000,0001. rsp_valid matches, delayed by 1 cycle, with the correct data per slot.
- req[1] with lock[1]=1 for 5 cycles while req[2] is also held -> gnt=0010 for 5 consecutive cycles. After lock[1] drops: gnt=0100 next, then 0010 again.
- Reset asserted one cycle after a grant to requester 3 -> gnt, rom_address and rsp_valid all 0 the cycle after reset. No rsp_valid for the dropped read; first post-reset contention goes to requester 0.
- ROM_LATENCY=2, requester 2 granted in cycle t -> rsp_valid=0100 in cycle t+2 only.
- SPRITE_ARB_STATS_EN, 3 cycles with req=0011 and 2 cycles with req=0001 -> contention_count=3. Forced over 65535 contention cycles -> holds at 16'hFFFF.
